// File: rtl/lfb_pkg.sv
// Shared types and constants for the logic function bank.
package lfb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } lfb_state_t;

  localparam int SIG_W = 16;
  localparam logic [SIG_W-1:0] LFSR_TAPS = 16'hB400;

  // Power-on function set for IN_W=4 builds that preload tables at reset.
  localparam logic [15:0] LFB_DEFAULT_TABLES [16] = '{
    16'h8000, 16'hFFFE, 16'h6996, 16'h0001,
    16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00,
    16'h7FFF, 16'h9669, 16'h0000, 16'hFFFF,
    16'h5555, 16'h3333, 16'h0F0F, 16'h00FF
  };

endpackage

// File: rtl/logic_function_bank_if.sv
// Config, evaluate, result and sweep-control signals of the logic function bank.
interface logic_function_bank_if
  import lfb_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_N = 10
);
  localparam int FN_W  = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int TBL_W = 1 << IN_W;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [FN_W-1:0]  cfg_fn;
  logic [TBL_W-1:0] cfg_table;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_bits;
  logic             out_valid;
  logic [OUT_N-1:0] out_bits;
  logic [IN_W-1:0]  out_idx;
  logic             sweep_start;
  logic             busy;
  logic             sweep_done;
  logic [SIG_W-1:0] signature;

  modport master (
    output cfg_valid, cfg_fn, cfg_table, in_valid, in_bits, sweep_start,
    input  cfg_ready, in_ready, out_valid, out_bits, out_idx, busy, sweep_done, signature
  );

  modport slave (
    input  cfg_valid, cfg_fn, cfg_table, in_valid, in_bits, sweep_start,
    output cfg_ready, in_ready, out_valid, out_bits, out_idx, busy, sweep_done, signature
  );

endinterface

// File: rtl/lfb_sig_lfsr.sv
// Signature register: shifts a Fibonacci LFSR and folds in one result word per update.
// Latency: new signature visible the cycle after upd; clr wins over upd.
// Backpressure: none, updates whenever upd is high.
module lfb_sig_lfsr
  import lfb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (upd) begin
      sig <= {sig[SIG_W-2:0], ^(sig & LFSR_TAPS)} ^ din;
    end
  end

endmodule

// File: rtl/logic_function_bank.sv
// Programmable truth-table bank with exhaustive self-check sweep (LFB_RESET_TABLE_EN: preload tables at reset).
// Latency: eval result registered 1 cycle after acceptance; sweep start-to-done 2^IN_W cycles.
// Backpressure: cfg/in ready only in IDLE; in_ready also drops while sweep_start is high.
module logic_function_bank
  import lfb_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_N = 10
)(
  input  logic                  clk,
  input  logic                  rst,
  logic_function_bank_if.slave  bus
);

  localparam int TBL_W = 1 << IN_W;

  lfb_state_t       state, state_nxt;
  logic [IN_W-1:0]  idx;
  logic [TBL_W-1:0] tables [OUT_N];
  logic [IN_W-1:0]  eval_vec;
  logic [OUT_N-1:0] eval_res;
  logic             cfg_rdy, in_rdy, cfg_fire, in_fire, sweep_go, sweeping;
  logic [SIG_W-1:0] sig_din;

  always_comb begin
    state_nxt = state;
    cfg_rdy   = 1'b0;
    in_rdy    = 1'b0;
    sweep_go  = 1'b0;
    case (state)
      IDLE: begin
        cfg_rdy  = 1'b1;
        in_rdy   = !bus.sweep_start;
        sweep_go = bus.sweep_start;
        if (bus.sweep_start) state_nxt = SWEEP;
      end
      SWEEP:   if (idx == '1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sweeping   = (state == SWEEP);
  assign cfg_fire   = bus.cfg_valid && cfg_rdy;
  assign in_fire    = bus.in_valid && in_rdy;
  assign eval_vec   = sweeping ? idx : bus.in_bits;
  assign sig_din    = SIG_W'(eval_res);

  assign bus.cfg_ready  = cfg_rdy;
  assign bus.in_ready   = in_rdy;
  assign bus.busy       = (state != IDLE);
  assign bus.sweep_done = (state == DONE);

  // Reads the tables before any same-edge write lands, so eval sees the old value.
  always_comb begin
    eval_res = '0;
    for (int j = 0; j < OUT_N; j++) begin
      eval_res[j] = tables[j][eval_vec];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_bits  <= '0;
      bus.out_idx   <= '0;
    end else begin
      bus.out_valid <= in_fire || sweeping;
      if (in_fire || sweeping) begin
        bus.out_bits <= eval_res;
        bus.out_idx  <= eval_vec;
      end
      if (sweep_go)      idx <= '0;
      else if (sweeping) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < OUT_N; j++) begin
`ifdef LFB_RESET_TABLE_EN
        tables[j] <= LFB_DEFAULT_TABLES[j];
`else
        tables[j] <= '0;
`endif
      end
    end else if (cfg_fire && (int'(bus.cfg_fn) < OUT_N)) begin
      tables[bus.cfg_fn] <= bus.cfg_table;
    end
  end

  lfb_sig_lfsr u_sig (
    .clk (clk),
    .rst (rst),
    .clr (sweep_go),
    .upd (sweeping),
    .din (sig_din),
    .sig (bus.signature)
  );

endmodule

// File: doc/logic_function_bank.md
# logic_function_bank

Registered, run-time-programmable bank of OUT_N Boolean functions of IN_W inputs, each stored as a 2^IN_W-bit truth table. It replaces hard-wired sum-of-products logic in the ALU datapath: functions are loaded over a config handshake, evaluated one input vector per cycle, or swept exhaustively by a built-in sequencer that compresses all results into a signature for self-check.

## Interface
- IN_W, 4, number of function inputs (2..6); in_bits[IN_W-1] is the MSB variable.
- OUT_N, 10, number of functions (1..16).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  table write request.
- cfg_ready  out  1  table write accepted when high with cfg_valid.
- cfg_fn  in  $clog2(OUT_N)  function index to write.
- cfg_table  in  2^IN_W  truth table; bit k = function value for input vector k.
- in_valid  in  1  evaluate request.
- in_ready  out  1  evaluation accepted when high with in_valid.
- in_bits  in  IN_W  input vector.
- out_valid  out  1  out_bits/out_idx valid this cycle.
- out_bits  out  OUT_N  bit j = function j at out_idx.
- out_idx  out  IN_W  input vector that produced out_bits.
- sweep_start  in  1  start exhaustive sweep (level sampled in IDLE).
- busy  out  1  high in SWEEP and DONE.
- sweep_done  out  1  one-cycle pulse at sweep end.
- signature  out  16  compressed sweep result.

## Operation
- States: IDLE, SWEEP, DONE. Reset -> IDLE.
- IDLE: cfg_ready=1, in_ready=1. Accepted cfg write updates table cfg_fn at the edge; cfg_fn >= OUT_N ignored (still accepted). Accepted eval registers out_bits[j]=table[j][in_bits], out_idx=in_bits, out_valid=1 next cycle; otherwise out_valid=0.
- Same-cycle cfg write and eval: eval sees the old table.
- IDLE with sweep_start=1: -> SWEEP, idx<=0, signature<=0. sweep_start has priority: a simultaneous in_valid is not accepted (in_ready=0 whenever sweep_start=1), a simultaneous cfg write is still performed.
- SWEEP: cfg_ready=0, in_ready=0, sweep_start ignored. Each cycle evaluates idx, registers result as for eval, idx increments; idx=2^IN_W-1 -> DONE (no wrap-around evaluation).
- Signature update on every registered sweep result: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ zero-extended out_bits.
- DONE: one cycle, sweep_done=1, then IDLE. signature holds until next sweep start or reset.
- Reset (any state, including mid-sweep): all tables 0, state IDLE, out_valid=0, out_bits=0, out_idx=0, signature=0, sweep_done=0, busy=0; cfg_ready/in_ready=1 after reset deasserts.

## Timing
- Eval latency 1 cycle, throughput 1/cycle.
- sweep_start sampled at edge t -> SWEEP from t; results for idx 0..2^IN_W-1 registered at edges t+1..t+2^IN_W; DONE from edge t+2^IN_W, sweep_done high that cycle with final signature valid; IDLE from edge t+2^IN_W+1.
- Default: sweep of 16 vectors, start-to-done 16 cycles, busy 17 cycles.

## Configuration
- LFB_RESET_TABLE_EN defined: reset loads a fixed default table set from the package (LFB_DEFAULT_TABLES, IN_W=4 only) instead of zeros. Undefined: reset clears all tables to 0. Interface identical either way.

## Structure
- Package lfb_pkg: state enum (IDLE/SWEEP/DONE), SIG_W=16, LFSR tap constant 16'hB400, LFB_DEFAULT_TABLES.
- One sub-module: lfb_sig_lfsr (16-bit signature register with clear/update enables).

## Test plan
- Reset, then eval in_bits=4'hF -> out_valid next cycle, out_bits=0, out_idx=4'hF.
- Write fn0=16'h8000, fn1=16'hFFFE, fn9=16'h6996; eval 4'hF -> out_bits[0]=1, [1]=1, [9]=0; eval 4'h0 -> [0]=0, [1]=0, [9]=0; eval 4'h1 -> [9]=1.
- All-zero tables, pulse sweep_start -> 16 consecutive out_valid with out_idx 0..15, sweep_done 16 cycles after start, signature=16'h0000.
- During SWEEP assert cfg_valid and in_valid -> cfg_ready=in_ready=0, tables unchanged, next sweep signature identical to bench model.
- Assert rst at sweep idx 7 -> all outputs 0 immediately, no sweep_done, tables cleared.
- Simultaneous write fn0=16'hFFFF and eval 4'h3 -> out_bits[0]=old value; next eval 4'h3 -> 1.
